uart_ctrl: RTL and testbench
============================

# uart_ctrl

Wishbone-slave UART controller for the RISC-V SoC. It sits between the CPU data bus and the `async_transmitter` / `async_receiver` pair instantiated beside it in the parent. It buffers outgoing bytes in a TX FIFO and sequences the transmitter's start/busy handshake. It drains the receiver's ready/clear handshake into an RX FIFO and exposes a 16550-style register subset, with RBR/THR at offset 0x0 and LSR at offset 0x5, so supervisor console code runs unmodified.

## Interface
- `TX_DEPTH`, 16: TX FIFO entries; power of two, at least 2.
- `RX_DEPTH`, 16: RX FIFO entries; power of two, at least 2.
- `clk`  in  1  system clock; the UART PHY runs on the same clock.
- `rst_n`  in  1  asynchronous active-low reset.
- `wb_cyc_i`, `wb_stb_i`, `wb_we_i`  in  1 each  Wishbone classic strobes.
- `wb_adr_i`  in  3  register byte offset.
- `wb_sel_i`  in  4  byte-lane selects.
- `wb_dat_i`  in  32  write data.
- `wb_dat_o`  out  32  read data.
- `wb_ack_o`  out  1  transfer acknowledge.
- `tx_start`  out  1  one-cycle start pulse to the transmitter.
- `tx_data`  out  8  byte to send.
- `tx_busy`  in  1  transmitter busy.
- `rx_ready`  in  1  receiver byte valid.
- `rx_data`  in  8  received byte.
- `rx_clear`  out  1  one-cycle clear pulse to the receiver.
- `irq_o`  out  1  level interrupt.

## Operation
- **Byte lane.** Lane = `wb_adr_i[1:0]`. Write data is taken from `wb_dat_i[8*lane+7:8*lane]`. A write is honoured only if `wb_sel_i[lane]` = 1. Read data is the register byte replicated on all four lanes.
- **Offset 0x0, read (RBR).** Returns the RX FIFO head and pops it. When the FIFO is empty, reads 0x00 and the pointers are unchanged.
- **Offset 0x0, write (THR).** Pushes the byte into the TX FIFO. A write to a full FIFO is dropped silently.
- **Offset 0x1, IER.** Bit 0 enables the RX-data interrupt; bit 1 enables the TX-empty interrupt. Other bits read 0.
- **Offset 0x5, LSR (read only).**
  - bit 0 DR: RX FIFO not empty.
  - bit 1 OE: overrun; sticky; cleared by an LSR read.
  - bit 5 THRE: TX FIFO not full.
  - bit 6 TEMT: TX FIFO empty, TX FSM in IDLE and `tx_busy` = 0.
  - Other bits read 0.
- **Other offsets.** Read 0x00; writes are ignored.
- **TX FSM.**
  - IDLE → START when the FIFO is non-empty and `tx_busy` = 0.
  - START (exactly one cycle): `tx_start` = 1, `tx_data` = head, pop.
  - START → WAIT_BUSY.
  - WAIT_BUSY → DRAIN on `tx_busy` = 1.
  - DRAIN → IDLE on `tx_busy` = 0.
  - `tx_data` holds its value until the next START.
- **RX FSM.**
  - IDLE → CLEAR on `rx_ready` = 1. On that transition, push `rx_data` if the RX FIFO is not full; otherwise set OE and drop the byte. `rx_clear` = 1 for exactly one cycle.
  - CLEAR → IDLE once `rx_ready` = 0.
- **Simultaneous events.**
  - RX push and RBR pop in the same cycle: both take effect and the count is unchanged. A push to a full FIFO with a simultaneous pop succeeds, with no OE.
  - OE set and LSR read in the same cycle: the read returns OE = 1 and OE remains set.
  - THR push and TX pop in the same cycle: both take effect.
- **Pointers.** Write/read pointers are log2(DEPTH) bits and wrap modulo DEPTH. The count is log2(DEPTH)+1 bits.

## Timing
- **Ack.** Registered. `wb_ack_o` = 1 for one cycle, in the cycle after `wb_cyc_i & wb_stb_i & !wb_ack_o`. Every transfer costs 2 cycles.
- **Side effects and read data.** All side effects (push, pop, IER write, OE clear) occur on the edge that raises `wb_ack_o`, once per transfer. `wb_dat_o` is valid while `wb_ack_o` = 1 and holds its value otherwise.
- **TX latency.** THR write into an empty FIFO with the PHY idle: `tx_start` rises on the edge after the ack edge.
- **RX latency.** `rx_ready` sampled high at edge M: push, `rx_clear` = 1 and DR = 1 all take effect from edge M.
- **`irq_o`.** Registered: `(IER[0] & DR) | (IER[1] & TX FIFO empty)`.
- **Reset values.**
  - Outputs: `wb_ack_o`, `wb_dat_o`, `tx_start`, `tx_data`, `rx_clear` and `irq_o` are all 0.
  - Registers: IER = 0, OE = 0, both FIFOs empty, both FSMs in IDLE.
  - Reset asserted mid-frame drops `tx_start` immediately. A byte already in the PHY completes; the controller waits for `tx_busy` = 0 before the next START.

## Configuration
- **`UART_IRQ_EN` defined:** IER and `irq_o` behave as specified.
- **`UART_IRQ_EN` undefined:** the IER register is removed and offset 0x1 reads 0 with writes ignored. The `irq_o` port remains, tied to 0.

## Test plan
- **Basic TX.** Reset, write THR = 0x41 with `wb_sel_i` = 4'b0001. Required: exactly one `tx_start` pulse with `tx_data` = 0x41; LSR = 0x60 once the PHY goes idle.
- **TX FIFO full.** Write 17 bytes 0x00–0x10 while holding `tx_busy` = 1. Required: THRE = 0 after the 16th write; 0x10 is never transmitted; the first 16 bytes go out in order.
- **Basic RX.** Pulse `rx_ready` with `rx_data` = 0x5A. Required: one `rx_clear` pulse; LSR = 0x61; RBR read returns 0x5A; a second RBR read returns 0x00 with DR = 0.
- **RX overrun.** Inject 17 bytes without reading. Required: LSR bit 1 = 1; the 16 stored bytes read back in order; the next LSR read shows OE = 0.
- **Interrupts (with `UART_IRQ_EN`).** Set IER = 0x01, inject one byte. Required: `irq_o` rises; it falls after the RBR read. Set IER = 0x02. Required: `irq_o` = 1 while the TX FIFO is empty. Without the macro, `irq_o` stays 0 and IER reads 0x00.
- **Reset mid-transfer.** Assert `rst_n` low during START. Required: `tx_start` drops at once; the FIFO is empty after release; no further `tx_start` until a new THR write.

Source files
------------

// File: rtl/uart_ctrl.sv
`timescale 1ns/1ps
// uart_ctrl -- Wishbone-slave UART controller (16550-style register subset).
//
// Sits between the CPU data bus and an async_transmitter / async_receiver
// pair. Outgoing bytes are buffered in a TX FIFO and handed to the
// transmitter with a start/busy handshake. Received bytes are drained from
// the receiver's ready/clear handshake into an RX FIFO.
//
// Register map (byte offsets, lane = wb_adr_i[1:0]):
//   0x0 read  RBR  RX FIFO head (pops), 0x00 when empty
//   0x0 write THR  push into TX FIFO (dropped when full)
//   0x1 r/w   IER  bit0 RX-data irq enable, bit1 TX-empty irq enable
//   0x5 read  LSR  bit0 DR, bit1 OE (sticky), bit5 THRE, bit6 TEMT
//
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   wb_cyc_i/stb_i/we_i        Wishbone classic strobes
//   wb_adr_i[2:0]              register byte offset
//   wb_sel_i[3:0]              byte-lane selects
//   wb_dat_i[31:0]/wb_dat_o    write / read data (read byte replicated x4)
//   wb_ack_o                   registered one-cycle acknowledge
//   tx_start, tx_data, tx_busy transmitter handshake
//   rx_ready, rx_data, rx_clear receiver handshake
//   irq_o                      registered level interrupt
//
// Configuration macro: UART_IRQ_EN. When undefined, IER is removed
// (offset 0x1 reads 0, writes ignored) and irq_o is tied to 0.
module uart_ctrl #(
  parameter int TX_DEPTH = 16,
  parameter int RX_DEPTH = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        wb_cyc_i,
  input  logic        wb_stb_i,
  input  logic        wb_we_i,
  input  logic [2:0]  wb_adr_i,
  input  logic [3:0]  wb_sel_i,
  input  logic [31:0] wb_dat_i,
  output logic [31:0] wb_dat_o,
  output logic        wb_ack_o,
  output logic        tx_start,
  output logic [7:0]  tx_data,
  input  logic        tx_busy,
  input  logic        rx_ready,
  input  logic [7:0]  rx_data,
  output logic        rx_clear,
  output logic        irq_o
);

  localparam int TX_AW = $clog2(TX_DEPTH);
  localparam int RX_AW = $clog2(RX_DEPTH);

  // ---------------------------------------------------------------- bus decode
  logic [1:0] lane;
  logic [7:0] wr_byte;
  logic       req;
  logic       wr_en;
  logic       rd_en;
  logic       thr_wr;
  logic       rbr_rd;
  logic       lsr_rd;

  assign lane = wb_adr_i[1:0];

  always_comb begin
    wr_byte = wb_dat_i[7:0];
    case (lane)
      2'd1:    wr_byte = wb_dat_i[15:8];
      2'd2:    wr_byte = wb_dat_i[23:16];
      2'd3:    wr_byte = wb_dat_i[31:24];
      default: wr_byte = wb_dat_i[7:0];
    endcase
  end

  // A transfer is accepted only while ack is low, so each transfer has
  // exactly one accepting edge and side effects happen once.
  assign req    = wb_cyc_i & wb_stb_i & ~wb_ack_o;
  assign wr_en  = req & wb_we_i & wb_sel_i[lane];
  assign rd_en  = req & ~wb_we_i;
  assign thr_wr = wr_en & (wb_adr_i == 3'd0);
  assign rbr_rd = rd_en & (wb_adr_i == 3'd0);
  assign lsr_rd = rd_en & (wb_adr_i == 3'd5);

  // ------------------------------------------------------------------ TX FIFO
  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_WAIT_BUSY, TX_DRAIN} tx_state_t;

  tx_state_t         tx_state;
  tx_state_t         tx_state_next;
  logic [7:0]        tx_mem [TX_DEPTH];
  logic [TX_AW-1:0]  tx_wr_ptr;
  logic [TX_AW-1:0]  tx_rd_ptr;
  logic [TX_AW:0]    tx_count;
  logic              tx_empty;
  logic              tx_full;
  logic              tx_push;
  logic              tx_pop;
  logic              tx_load;

  assign tx_empty = (tx_count == '0);
  // Depth is a power of two, so the count MSB alone flags "full".
  assign tx_full  = tx_count[TX_AW];
  assign tx_push  = thr_wr & ~tx_full;

  always_ff @(posedge clk) begin
    if (tx_push) tx_mem[tx_wr_ptr] <= wr_byte;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_wr_ptr <= '0;
      tx_rd_ptr <= '0;
      tx_count  <= '0;
    end else begin
      if (tx_push) tx_wr_ptr <= tx_wr_ptr + TX_AW'(1);
      if (tx_pop)  tx_rd_ptr <= tx_rd_ptr + TX_AW'(1);
      tx_count <= tx_count + (TX_AW+1)'(tx_push) - (TX_AW+1)'(tx_pop);
    end
  end

  // ------------------------------------------------------------------- TX FSM
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_state <= TX_IDLE;
      tx_data  <= 8'h00;
    end else begin
      tx_state <= tx_state_next;
      // Latch the head on entry to START so tx_data is valid with tx_start
      // and then holds until the next START.
      if (tx_load) tx_data <= tx_mem[tx_rd_ptr];
    end
  end

  always_comb begin
    tx_state_next = tx_state;
    tx_start      = 1'b0;
    tx_pop        = 1'b0;
    tx_load       = 1'b0;
    case (tx_state)
      TX_IDLE: begin
        if (!tx_empty && !tx_busy) begin
          tx_state_next = TX_START;
          tx_load       = 1'b1;
        end
      end
      TX_START: begin
        tx_start      = 1'b1;
        tx_pop        = 1'b1;
        tx_state_next = TX_WAIT_BUSY;
      end
      TX_WAIT_BUSY: begin
        if (tx_busy) tx_state_next = TX_DRAIN;
      end
      TX_DRAIN: begin
        if (!tx_busy) tx_state_next = TX_IDLE;
      end
      default: tx_state_next = TX_IDLE;
    endcase
  end

  // ------------------------------------------------------------------ RX FIFO
  typedef enum logic {RX_IDLE, RX_CLEAR} rx_state_t;

  rx_state_t         rx_state;
  rx_state_t         rx_state_next;
  logic [7:0]        rx_mem [RX_DEPTH];
  logic [RX_AW-1:0]  rx_wr_ptr;
  logic [RX_AW-1:0]  rx_rd_ptr;
  logic [RX_AW:0]    rx_count;
  logic              rx_empty;
  logic              rx_full;
  logic              rx_take;
  logic              rx_push;
  logic              rx_pop;
  logic              oe_set;
  logic              oe;

  assign rx_empty = (rx_count == '0);
  assign rx_full  = rx_count[RX_AW];
  assign rx_pop   = rbr_rd & ~rx_empty;
  // A simultaneous RBR pop frees a slot, so a byte arriving on a full FIFO
  // still lands and no overrun is flagged.
  assign rx_push  = rx_take & (~rx_full | rx_pop);
  assign oe_set   = rx_take & rx_full & ~rx_pop;

  always_ff @(posedge clk) begin
    if (rx_push) rx_mem[rx_wr_ptr] <= rx_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_wr_ptr <= '0;
      rx_rd_ptr <= '0;
      rx_count  <= '0;
      rx_state  <= RX_IDLE;
      rx_clear  <= 1'b0;
      oe        <= 1'b0;
    end else begin
      if (rx_push) rx_wr_ptr <= rx_wr_ptr + RX_AW'(1);
      if (rx_pop)  rx_rd_ptr <= rx_rd_ptr + RX_AW'(1);
      rx_count <= rx_count + (RX_AW+1)'(rx_push) - (RX_AW+1)'(rx_pop);
      rx_state <= rx_state_next;
      // Registered so the pulse is one cycle even if rx_ready lingers.
      rx_clear <= rx_take;
      // A new overrun wins over a same-cycle LSR read.
      if (oe_set)      oe <= 1'b1;
      else if (lsr_rd) oe <= 1'b0;
    end
  end

  always_comb begin
    rx_state_next = rx_state;
    rx_take       = 1'b0;
    case (rx_state)
      RX_IDLE: begin
        if (rx_ready) begin
          rx_take       = 1'b1;
          rx_state_next = RX_CLEAR;
        end
      end
      RX_CLEAR: begin
        if (!rx_ready) rx_state_next = RX_IDLE;
      end
      default: rx_state_next = RX_IDLE;
    endcase
  end

  // ---------------------------------------------------------------- IER / IRQ
  logic [1:0] ier;

`ifdef UART_IRQ_EN
  logic ier_wr;
  assign ier_wr = wr_en & (wb_adr_i == 3'd1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ier   <= 2'b00;
      irq_o <= 1'b0;
    end else begin
      if (ier_wr) ier <= wr_byte[1:0];
      irq_o <= (ier[0] & ~rx_empty) | (ier[1] & tx_empty);
    end
  end
`else
  assign ier   = 2'b00;
  assign irq_o = 1'b0;
`endif

  // ---------------------------------------------------------------- read path
  logic       thre;
  logic       temt;
  logic [7:0] lsr;
  logic [7:0] rd_byte;

  assign thre = ~tx_full;
  assign temt = tx_empty & (tx_state == TX_IDLE) & ~tx_busy;
  // OE reads as set when an overrun lands in the same cycle as the read.
  assign lsr  = {1'b0, temt, thre, 3'b000, oe | oe_set, ~rx_empty};

  always_comb begin
    rd_byte = 8'h00;
    case (wb_adr_i)
      3'd0:    rd_byte = rx_empty ? 8'h00 : rx_mem[rx_rd_ptr];
      3'd1:    rd_byte = {6'b000000, ier};
      3'd5:    rd_byte = lsr;
      default: rd_byte = 8'h00;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wb_ack_o <= 1'b0;
      wb_dat_o <= 32'h0;
    end else begin
      wb_ack_o <= req;
      if (rd_en) wb_dat_o <= {4{rd_byte}};
    end
  end

endmodule

// File: tb/tb_uart_ctrl.sv
`timescale 1ns/1ps
// tb_uart_ctrl -- directed self-checking bench for uart_ctrl.
// A small PHY model raises tx_busy for a few cycles after each tx_start and
// logs every transmitted byte; hold_busy forces the PHY busy.
module tb_uart_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        wb_cyc_i = 1'b0;
  logic        wb_stb_i = 1'b0;
  logic        wb_we_i = 1'b0;
  logic [2:0]  wb_adr_i = 3'd0;
  logic [3:0]  wb_sel_i = 4'd0;
  logic [31:0] wb_dat_i = 32'h0;
  logic [31:0] wb_dat_o;
  logic        wb_ack_o;
  logic        tx_start;
  logic [7:0]  tx_data;
  logic        tx_busy;
  logic        rx_ready = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_clear;
  logic        irq_o;

  logic        hold_busy = 1'b0;
  int          phy_cnt = 0;
  int          tx_start_cnt = 0;
  int          rx_clear_cnt = 0;
  logic [7:0]  tx_log[$];

  int          errors = 0;
  int          checks = 0;

  uart_ctrl #(.TX_DEPTH(16), .RX_DEPTH(16)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .wb_cyc_i (wb_cyc_i),
    .wb_stb_i (wb_stb_i),
    .wb_we_i  (wb_we_i),
    .wb_adr_i (wb_adr_i),
    .wb_sel_i (wb_sel_i),
    .wb_dat_i (wb_dat_i),
    .wb_dat_o (wb_dat_o),
    .wb_ack_o (wb_ack_o),
    .tx_start (tx_start),
    .tx_data  (tx_data),
    .tx_busy  (tx_busy),
    .rx_ready (rx_ready),
    .rx_data  (rx_data),
    .rx_clear (rx_clear),
    .irq_o    (irq_o)
  );

  always #5 clk = ~clk;

  assign tx_busy = hold_busy | (phy_cnt != 0);

  // PHY model: not reset by rst_n, so a byte in flight completes.
  always @(posedge clk) begin
    if (tx_start) begin
      phy_cnt      <= 6;
      tx_start_cnt <= tx_start_cnt + 1;
      tx_log.push_back(tx_data);
    end else if (phy_cnt != 0) begin
      phy_cnt <= phy_cnt - 1;
    end
    if (rx_clear) rx_clear_cnt <= rx_clear_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end else begin
      $display("ok   %s = %h", tag, got);
    end
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wb_write(input logic [2:0] adr, input logic [3:0] sel, input logic [31:0] dat);
    bit got = 0;
    @(posedge clk); #1;
    wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = 1'b1;
    wb_adr_i = adr; wb_sel_i = sel; wb_dat_i = dat;
    for (int i = 0; i < 4 && !got; i++) begin
      @(posedge clk); #1;
      if (wb_ack_o) got = 1;
    end
    wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0;
    if (!got) check("wb_write_ack", 32'd0, 32'd1);
    $display("wb write adr=%0h sel=%b dat=%h", adr, sel, dat);
  endtask

  task automatic wb_read(input logic [2:0] adr, output logic [31:0] dat);
    bit got = 0;
    dat = 32'hxxxxxxxx;
    @(posedge clk); #1;
    wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = 1'b0;
    wb_adr_i = adr; wb_sel_i = 4'hf;
    for (int i = 0; i < 4 && !got; i++) begin
      @(posedge clk); #1;
      if (wb_ack_o) begin
        got = 1;
        dat = wb_dat_o;
      end
    end
    wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
    if (!got) check("wb_read_ack", 32'd0, 32'd1);
    $display("wb read  adr=%0h dat=%h", adr, dat);
  endtask

  // Drives rx_ready until rx_clear is seen; lat is the number of edges
  // after the sampling edge before rx_clear was observed.
  task automatic rx_inject(input logic [7:0] b, output int lat);
    bit seen = 0;
    lat = -1;
    @(posedge clk); #1;
    rx_ready = 1'b1; rx_data = b;
    for (int i = 0; i < 5 && !seen; i++) begin
      @(posedge clk); #1;
      if (rx_clear) begin
        seen = 1;
        lat = i;
      end
    end
    rx_ready = 1'b0;
    if (!seen) check("rx_clear_seen", 32'd0, 32'd1);
    $display("rx inject byte=%h", b);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd;
    int          base;
    int          lat;
    int          n;

    // ---------------- reset
    wait_cycles(3);
    check("rst_ack",      32'(wb_ack_o), 32'd0);
    check("rst_dat_o",    wb_dat_o,      32'h0);
    check("rst_tx_start", 32'(tx_start), 32'd0);
    check("rst_tx_data",  32'(tx_data),  32'd0);
    check("rst_rx_clear", 32'(rx_clear), 32'd0);
    check("rst_irq",      32'(irq_o),    32'd0);
    @(negedge clk); rst_n = 1'b1;
    wait_cycles(2);
    wb_read(3'd5, rd);
    check("rst_lsr", rd, 32'h60606060);

    // ---------------- basic TX
    base = tx_start_cnt;
    wb_write(3'd0, 4'b0001, 32'h00000041);
    wait_cycles(1);
    check("tx_start_lat", 32'(tx_start), 32'd1);
    check("tx_data_41",   32'(tx_data),  32'h41);
    wait_cycles(20);
    check("tx_one_pulse", 32'(tx_start_cnt - base), 32'd1);
    check("tx_log_41",    32'(tx_log[tx_log.size()-1]), 32'h41);
    wb_read(3'd5, rd);
    check("tx_lsr_idle", rd, 32'h60606060);

    // lane 0 write with sel[0]=0 is not honoured
    base = tx_start_cnt;
    wb_write(3'd0, 4'b0010, 32'h00004200);
    wait_cycles(20);
    check("thr_sel_masked", 32'(tx_start_cnt - base), 32'd0);

    // ---------------- TX FIFO full
    hold_busy = 1'b1;
    base = tx_log.size();
    for (int i = 0; i < 17; i++) begin
      wb_write(3'd0, 4'b0001, 32'(i));
      if (i == 14) begin
        wb_read(3'd5, rd);
        check("thre_15", rd, 32'h20202020);
      end
      if (i == 15) begin
        wb_read(3'd5, rd);
        check("thre_16_full", rd, 32'h00000000);
      end
    end
    hold_busy = 1'b0;
    n = 0;
    while (tx_log.size() < base + 16 && n < 400) begin
      wait_cycles(1);
      n++;
    end
    wait_cycles(40);
    check("tx_full_count", 32'(tx_log.size() - base), 32'd16);
    for (int i = 0; i < 16; i++) begin
      if (base + i < tx_log.size())
        check($sformatf("tx_order_%0d", i), 32'(tx_log[base+i]), 32'(i));
      else
        check($sformatf("tx_order_%0d", i), 32'hffffffff, 32'(i));
    end

    // ---------------- basic RX
    base = rx_clear_cnt;
    rx_inject(8'h5A, lat);
    check("rx_clear_lat", 32'(lat), 32'd0);
    wb_read(3'd5, rd);
    check("rx_lsr_dr", rd, 32'h61616161);
    check("rx_clear_once", 32'(rx_clear_cnt - base), 32'd1);
    wb_read(3'd0, rd);
    check("rbr_5a", rd, 32'h5A5A5A5A);
    wb_read(3'd0, rd);
    check("rbr_empty", rd, 32'h00000000);
    wb_read(3'd5, rd);
    check("rx_lsr_dr0", rd, 32'h60606060);

    // ---------------- RX overrun
    for (int i = 0; i < 17; i++) rx_inject(8'(8'h80 + i), lat);
    wb_read(3'd5, rd);
    check("ovr_lsr_oe", rd, 32'h63636363);
    for (int i = 0; i < 16; i++) begin
      wb_read(3'd0, rd);
      check($sformatf("ovr_rbr_%0d", i), rd, {4{8'(8'h80 + i)}});
    end
    wb_read(3'd5, rd);
    check("ovr_lsr_clr", rd, 32'h60606060);

    // ---------------- other offsets
    wb_read(3'd2, rd);
    check("rd_off2", rd, 32'h0);
    wb_read(3'd7, rd);
    check("rd_off7", rd, 32'h0);
    wb_write(3'd5, 4'hf, 32'hffffffff);
    wb_read(3'd5, rd);
    check("lsr_wr_ignored", rd, 32'h60606060);

    // ---------------- interrupts
`ifdef UART_IRQ_EN
    wb_write(3'd1, 4'b0010, 32'h00000100);
    wb_read(3'd1, rd);
    check("ier_01", rd, 32'h01010101);
    wait_cycles(2);
    check("irq_idle", 32'(irq_o), 32'd0);
    rx_inject(8'h33, lat);
    wait_cycles(2);
    check("irq_rx", 32'(irq_o), 32'd1);
    wb_read(3'd0, rd);
    check("irq_rbr", rd, 32'h33333333);
    wait_cycles(2);
    check("irq_rx_fall", 32'(irq_o), 32'd0);
    wb_write(3'd1, 4'b0010, 32'h0000ff00);
    wb_read(3'd1, rd);
    check("ier_mask", rd, 32'h03030303);
    wait_cycles(2);
    check("irq_tx_empty", 32'(irq_o), 32'd1);
    wb_write(3'd1, 4'b0010, 32'h00000000);
`else
    wb_write(3'd1, 4'b0010, 32'h0000ff00);
    wb_read(3'd1, rd);
    check("ier_absent", rd, 32'h0);
    rx_inject(8'h33, lat);
    wait_cycles(3);
    check("irq_tied", 32'(irq_o), 32'd0);
    wb_read(3'd0, rd);
    check("irq_rbr", rd, 32'h33333333);
`endif

    // ---------------- reset mid-transfer
    wb_write(3'd0, 4'b0001, 32'h00000077);
    wait_cycles(1);
    check("mid_start", 32'(tx_start), 32'd1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_drop", 32'(tx_start), 32'd0);
    base = tx_start_cnt;
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    wb_read(3'd5, rd);
    check("mid_fifo_empty", rd, 32'h60606060);
    wait_cycles(20);
    check("mid_no_start", 32'(tx_start_cnt - base), 32'd0);
    wb_write(3'd0, 4'b0001, 32'h00000078);
    wait_cycles(20);
    check("mid_new_start", 32'(tx_start_cnt - base), 32'd1);
    check("mid_new_byte", 32'(tx_log[tx_log.size()-1]), 32'h78);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
